// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - RV32M multiply/divide unit with single-cycle multiply and restoring divider
// Optional feature macro: MULDIV_EARLY_OUT_EN (divides with |a| < |b| finish in one cycle)
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            rd_in,
  input  logic                  flush,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [4:0]            rd_out
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic [4:0]     rd_q, rd_d;
  logic [4:0]     rd_out_q, rd_out_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;

  // Multiply: operands widened to 33 bits with per-op sign, then to 2W so the
  // low 2W bits of an unsigned product equal the signed product.
  logic           a_mul_sgn, b_mul_sgn;
  logic [W:0]     a_ext, b_ext;
  logic [2*W-1:0] a_mul, b_mul, prod;
  logic [W-1:0]   mul_res;

  // Divide setup helpers evaluated on the incoming operands.
  logic           div_signed, a_neg, b_neg;
  logic [W-1:0]   mag_a, mag_b;
  logic           div_by_zero, div_ovf;
  logic [W-1:0]   spec_res;

  // One restoring step on the registered divider state.
  logic [W:0]     rem_sh, trial;
  logic           step_ge;
  logic [W-1:0]   rem_next, quo_next, quo_fin, rem_fin;

  // Operand conditioning, product and divider datapath
  always_comb begin
    a_mul_sgn = (op != 3'd3);
    b_mul_sgn = ~op[1];
    a_ext     = {a_mul_sgn & a[W-1], a};
    b_ext     = {b_mul_sgn & b[W-1], b};
    a_mul     = {{(W-1){a_ext[W]}}, a_ext};
    b_mul     = {{(W-1){b_ext[W]}}, b_ext};
    prod      = a_mul * b_mul;
    mul_res   = (op[1:0] == 2'd0) ? prod[W-1:0] : prod[2*W-1:W];

    div_signed  = ~op[0];
    a_neg       = div_signed & a[W-1];
    b_neg       = div_signed & b[W-1];
    mag_a       = a_neg ? (~a + 1'b1) : a;
    mag_b       = b_neg ? (~b + 1'b1) : b;
    div_by_zero = (b == '0);
    div_ovf     = div_signed & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
    if (div_by_zero) begin
      spec_res = op[1] ? a : '1;
    end else begin
      spec_res = op[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    rem_sh   = {rem_q, quo_q[W-1]};
    trial    = rem_sh - {1'b0, dvs_q};
    step_ge  = ~trial[W];
    rem_next = step_ge ? trial[W-1:0] : rem_sh[W-1:0];
    quo_next = {quo_q[W-2:0], step_ge};
    quo_fin  = neg_quo_q ? (~quo_next + 1'b1) : quo_next;
    rem_fin  = neg_rem_q ? (~rem_next + 1'b1) : rem_next;
  end

  // Next-state and register updates for the IDLE/BUSY/DONE control
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rd_out_d  = rd_out_q;
    result_d  = result_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d = op;
          rd_d = rd_in;
          if (!op[2]) begin
            result_d = mul_res;
            rd_out_d = rd_in;
            state_d  = DONE;
          end else if (div_by_zero || div_ovf) begin
            result_d = spec_res;
            rd_out_d = rd_in;
            state_d  = DONE;
          end
`ifdef MULDIV_EARLY_OUT_EN
          else if (mag_a < mag_b) begin
            result_d = op[1] ? a : '0;
            rd_out_d = rd_in;
            state_d  = DONE;
          end
`endif
          else begin
            quo_d     = mag_a;
            dvs_d     = mag_b;
            rem_d     = '0;
            cnt_d     = CW'(W);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quo_d = quo_next;
          rem_d = rem_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            result_d = op_q[1] ? rem_fin : quo_fin;
            rd_out_d = rd_q;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rd_out_q  <= '0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rd_out_q  <= rd_out_d;
      result_q  <= result_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Pipeline hold: combinational, dropped immediately on a redirect
  always_comb begin
    stall  = ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
    done   = (state_q == DONE);
    result = result_q;
    rd_out = rd_out_q;
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - scoreboard bench for ex_muldiv_unit
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        flush = 1'b0;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result),
    .rd_out (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, t;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin t = sx * sy; return t[31:0]; end
      3'd1: begin t = sx * sy; return t[63:32]; end
      3'd2: begin t = sx * longint'({32'd0, y}); return t[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        t = sx / sy; return t[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        t = sx % sy; return t[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint mx, my;
    if (!o[2]) return 1;
    if (y == 0) return 1;
    if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    if (!o[0]) begin
      mx = longint'($signed(x)); if (mx < 0) mx = -mx;
      my = longint'($signed(y)); if (my < 0) my = -my;
    end else begin
      mx = longint'({32'd0, x});
      my = longint'({32'd0, y});
    end
`ifdef MULDIV_EARLY_OUT_EN
    if (mx < my) return 1;
`endif
    return 33;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r);
    exp_t e;
    exp_t p;
    int   stalls;
    bit   seen;
    e.res = model_res(o, x, y);
    e.rd  = r;
    e.lat = model_lat(o, x, y);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    stalls = 0;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      #1;
      if (done) begin
        p = sb.pop_front();
        check_eq({tag, " result"}, {32'd0, result}, {32'd0, p.res});
        check_eq({tag, " rd_out"}, {59'd0, rd_out}, {59'd0, p.rd});
        check_eq({tag, " latency"}, 64'(c), 64'(p.lat));
        check_eq({tag, " stall_cycles"}, 64'(stalls), 64'(p.lat));
        check_eq({tag, " stall_in_done"}, {63'd0, stall}, 64'd0);
        seen = 1'b1;
        break;
      end
      if (stall) stalls++;
      @(negedge clk);
    end
    if (!seen) begin
      check_eq({tag, " timeout"}, {63'd0, seen}, 64'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    check_eq({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    check_eq({tag, " result_hold"}, {32'd0, result}, {32'd0, e.res});
  endtask

  initial begin
    int done_seen;
    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("reset stall", {63'd0, stall}, 64'd0);
    check_eq("reset done", {63'd0, done}, 64'd0);
    check_eq("reset result", {32'd0, result}, 64'd0);
    check_eq("reset rd_out", {59'd0, rd_out}, 64'd0);

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    run_op("mulh_neg", 3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd3);
    run_op("mulhsu_neg", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    run_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op("divu_by0", 3'd5, 32'd10, 32'd0, 5'd7);
    run_op("remu_by0", 3'd7, 32'd10, 32'd0, 5'd8);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op("divu_3_9", 3'd5, 32'd3, 32'd9, 5'd11);
    run_op("remu_3_9", 3'd7, 32'd3, 32'd9, 5'd12);
    run_op("rem_7_m3", 3'd6, 32'd7, 32'hFFFF_FFFD, 5'd13);

    // flush during BUSY at cycle 10
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd14;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("flush stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (done) done_seen++;
      @(negedge clk);
    end
    check_eq("flush no_done", 64'(done_seen), 64'd0);
    check_eq("flush idle_stall", {63'd0, stall}, 64'd0);

    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd15);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd16);

    for (int i = 0; i < 8; i++) begin
      run_op("rand", 3'($urandom_range(0, 7)), $urandom, $urandom_range(1, 32'hFFFF), 5'($urandom));
    end

    // reset during BUSY
    @(negedge clk);
    start = 1'b1; op = 3'd5; a = 32'd100; b = 32'd7; rd_in = 5'd17;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    check_eq("rst_busy stall", {63'd0, stall}, 64'd0);
    check_eq("rst_busy done", {63'd0, done}, 64'd0);
    check_eq("rst_busy result", {32'd0, result}, 64'd0);
    check_eq("rst_busy rd_out", {59'd0, rd_out}, 64'd0);

    run_op("div_after_rst", 3'd4, 32'd1000, 32'hFFFF_FFF6, 5'd18);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
